// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, memory wait, EX redirect.
// Optional HAZARD_PERF_CNT_EN adds saturating 32-bit stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 64,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] IF_ID_rs1,
    input  logic [4:0] IF_ID_rs2,
    input  logic       IF_ID_use_rs1,
    input  logic       IF_ID_use_rs2,
    input  logic       ID_EX_memread,
    input  logic [4:0] ID_EX_rd,
    input  logic       EX_redirect,
    input  logic       EX_MEM_memread,
    input  logic       EX_MEM_memwrite,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic       IF_ID_write,
    output logic       IF_ID_flush,
    output logic       ID_stall,
    output logic       ID_EX_hold,
    output logic       EX_stall,
    output logic       EX_MEM_hold,
    output logic       MEM_WB_bubble,
    output logic       mem_error
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_lu_stalls,
    output logic [31:0] perf_mem_stalls,
    output logic [31:0] perf_flushes
`endif
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        FLUSH
    } state_t;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
    localparam logic [2:0] FCL = 3'(FLUSH_CYCLES);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic [2:0] flush_cnt, flush_nxt;
    logic       pending, pending_nxt;
    logic       err_set;

    logic mem_access, mem_stall, load_use;
    logic freeze, flush, lu_stall, tmo_bubble;

    assign mem_access = EX_MEM_memread | EX_MEM_memwrite;
    assign mem_stall  = mem_access & ~dmem_ready;
    assign load_use   = ID_EX_memread && (ID_EX_rd != 5'd0) &&
                        ((IF_ID_use_rs1 && (IF_ID_rs1 == ID_EX_rd)) ||
                         (IF_ID_use_rs2 && (IF_ID_rs2 == ID_EX_rd)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            flush_cnt <= 3'd0;
            pending   <= 1'b0;
            mem_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            flush_cnt <= flush_nxt;
            pending   <= pending_nxt;
            if (err_set) mem_error <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        flush_nxt   = flush_cnt;
        pending_nxt = pending;
        err_set     = 1'b0;
        freeze      = 1'b0;
        flush       = 1'b0;
        lu_stall    = 1'b0;
        tmo_bubble  = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    // a redirect seen while entering the wait is replayed on ready
                    freeze      = 1'b1;
                    state_nxt   = MEM_WAIT;
                    wait_nxt    = 8'd1;
                    pending_nxt = EX_redirect;
                end else if (EX_redirect) begin
                    flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = FLUSH;
                        flush_nxt = 3'd1;
                    end
                end else if (load_use) begin
                    lu_stall = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt   = RUN;
                    pending_nxt = 1'b0;
                    if (pending) begin
                        flush = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_nxt = FLUSH;
                            flush_nxt = 3'd1;
                        end
                    end
                end else if (wait_cnt == TMO) begin
                    err_set     = 1'b1;
                    tmo_bubble  = 1'b1;
                    state_nxt   = RUN;
                    pending_nxt = 1'b0;
                end else begin
                    freeze   = 1'b1;
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            FLUSH: begin
                if (mem_stall) begin
                    freeze      = 1'b1;
                    state_nxt   = MEM_WAIT;
                    wait_nxt    = 8'd1;
                    pending_nxt = 1'b0;
                end else begin
                    flush = 1'b1;
                    if (EX_redirect) begin
                        flush_nxt = 3'd1;
                    end else if (3'(flush_cnt + 3'd1) == FCL) begin
                        state_nxt = RUN;
                    end else begin
                        flush_nxt = flush_cnt + 3'd1;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign pc_write      = ~(freeze | lu_stall);
    assign IF_ID_write   = ~(freeze | lu_stall);
    assign IF_ID_flush   = flush;
    assign ID_stall      = flush | lu_stall;
    assign ID_EX_hold    = freeze;
    assign EX_stall      = 1'b0;
    assign EX_MEM_hold   = freeze;
    assign MEM_WB_bubble = freeze | tmo_bubble;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_lu_stalls  <= 32'd0;
            perf_mem_stalls <= 32'd0;
            perf_flushes    <= 32'd0;
        end else begin
            if (lu_stall && perf_lu_stalls != '1)
                perf_lu_stalls <= perf_lu_stalls + 32'd1;
            if (state == MEM_WAIT && perf_mem_stalls != '1)
                perf_mem_stalls <= perf_mem_stalls + 32'd1;
            if (flush && perf_flushes != '1)
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios
// followed by randomized traffic against a remaining-cycles behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int MT = 4;
    localparam int FC = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, ld_ex, redir, mrd, mwr, rdy;
    logic       pc_write, IF_ID_write, IF_ID_flush, ID_stall, ID_EX_hold;
    logic       EX_stall, EX_MEM_hold, MEM_WB_bubble, mem_error;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_stalls, perf_mem_stalls, perf_flushes;
`endif

    int total = 0;
    int bad   = 0;

    // model state: in a memory wait, cycles waited, flush cycles still owed
    bit m_wait, n_wait;
    int m_waited, n_waited;
    int m_fl, n_fl;
    bit m_pend, n_pend;
    bit m_err, n_err;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .FLUSH_CYCLES(FC)) dut (
        .clk(clk),
        .reset(reset),
        .IF_ID_rs1(rs1),
        .IF_ID_rs2(rs2),
        .IF_ID_use_rs1(use1),
        .IF_ID_use_rs2(use2),
        .ID_EX_memread(ld_ex),
        .ID_EX_rd(rd),
        .EX_redirect(redir),
        .EX_MEM_memread(mrd),
        .EX_MEM_memwrite(mwr),
        .dmem_ready(rdy),
        .pc_write(pc_write),
        .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush),
        .ID_stall(ID_stall),
        .ID_EX_hold(ID_EX_hold),
        .EX_stall(EX_stall),
        .EX_MEM_hold(EX_MEM_hold),
        .MEM_WB_bubble(MEM_WB_bubble),
        .mem_error(mem_error)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_lu_stalls(perf_lu_stalls),
        .perf_mem_stalls(perf_mem_stalls),
        .perf_flushes(perf_flushes)
`endif
    );

    wire [8:0] outs = {pc_write, IF_ID_write, IF_ID_flush, ID_stall,
                       ID_EX_hold, EX_stall, EX_MEM_hold, MEM_WB_bubble,
                       mem_error};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        rs1 = 0; rs2 = 0; rd = 0; use1 = 0; use2 = 0; ld_ex = 0;
        redir = 0; mrd = 0; mwr = 0; rdy = 1;
    endtask

    task automatic model_reset();
        m_wait = 0; m_waited = 0; m_fl = 0; m_pend = 0; m_err = 0;
    endtask

    task automatic eval_model(output logic [8:0] e);
        bit fr, fl, lu, tb, lu_hit, ms;
        fr = 0; fl = 0; lu = 0; tb = 0;
        n_wait = m_wait; n_waited = m_waited; n_fl = m_fl;
        n_pend = m_pend; n_err = m_err;
        ms = (mrd | mwr) & ~rdy;
        lu_hit = ld_ex && rd != 0 &&
                 ((use1 && rs1 == rd) || (use2 && rs2 == rd));
        if (m_wait) begin
            if (rdy) begin
                n_wait = 0;
                if (m_pend) begin
                    fl = 1;
                    n_fl = FC - 1;
                end
                n_pend = 0;
            end else if (m_waited == MT) begin
                n_err = 1; tb = 1; n_wait = 0; n_pend = 0;
            end else begin
                fr = 1;
                n_waited = m_waited + 1;
            end
        end else if (ms) begin
            fr = 1; n_wait = 1; n_waited = 1;
            n_pend = (m_fl == 0) && redir;
            n_fl = 0;
        end else if (m_fl > 0 || redir) begin
            fl = 1;
            n_fl = redir ? FC - 1 : m_fl - 1;
        end else if (lu_hit) begin
            lu = 1;
        end
        e = {~(fr | lu), ~(fr | lu), fl, fl | lu, fr, 1'b0, fr,
             fr | tb, m_err};
    endtask

    // inputs are set at the falling edge; outputs checked 1 unit later
    task automatic tick(input string tag);
        logic [8:0] e;
        eval_model(e);
        #1;
        chk(tag, 32'(outs), 32'(e));
        @(posedge clk);
        m_wait = n_wait; m_waited = n_waited; m_fl = n_fl;
        m_pend = n_pend; m_err = n_err;
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        idle();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk(tag, 32'(outs), 32'h180);
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "_perf"}, perf_lu_stalls | perf_mem_stalls | perf_flushes, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int stuck;
        idle();
        model_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_outs", 32'(outs), 32'h180);
        reset = 1'b0;
        tick("idle");

        // load-use: one stall, then the bubble clears it
        ld_ex = 1; rd = 5; rs1 = 5; use1 = 1;
        tick("lu_stall");
        chk("lu_pcw", 32'(pc_write), 0);
        ld_ex = 0;
        tick("lu_after");
        ld_ex = 1; rd = 0; rs1 = 0;
        tick("lu_rd0");
        idle();

        // memory wait: 3 low cycles after entry, then ready
        mrd = 1; rdy = 0;
        repeat (4) tick("mw_frz");
        rdy = 1;
        tick("mw_rdy");
        idle();
        tick("mw_idle");

        // redirect on entry to wait is replayed on ready
        mrd = 1; rdy = 0; redir = 1;
        tick("rw_entry");
        redir = 0;
        repeat (2) tick("rw_wait");
        rdy = 1;
        tick("rw_rdy");
        chk("rw_flush", 32'(IF_ID_flush), 1);
        mrd = 0;
        repeat (3) tick("rw_tail");

        // timeout sets sticky mem_error
        mrd = 1; rdy = 0;
        repeat (6) tick("tmo");
        idle();
        repeat (2) tick("tmo_after");
        chk("tmo_err", 32'(mem_error), 1);
        async_reset("rst_err");
        tick("err_clr");

        // flush length and extension
        redir = 1;
        tick("fl_1");
        redir = 0;
        repeat (3) tick("fl_n");
        redir = 1;
        tick("fx_1");
        tick("fx_2");
        redir = 0;
        repeat (3) tick("fx_n");

        // reset mid-MEM_WAIT and mid-FLUSH
        mrd = 1; rdy = 0;
        repeat (2) tick("pre_rst_mw");
        async_reset("rst_mw");
        tick("post_rst_mw");
        redir = 1;
        tick("pre_rst_fl");
        redir = 0;
        async_reset("rst_fl");
        tick("post_rst_fl");

        stuck = 0;
        for (int i = 0; i < 3000; i++) begin
            rs1   = 5'($urandom_range(0, 3));
            rs2   = 5'($urandom_range(0, 3));
            rd    = 5'($urandom_range(0, 3));
            use1  = 1'($urandom);
            use2  = 1'($urandom);
            ld_ex = ($urandom_range(0, 2) == 0);
            redir = ($urandom_range(0, 5) == 0);
            mrd   = ($urandom_range(0, 3) == 0);
            mwr   = ($urandom_range(0, 5) == 0);
            if (stuck == 0 && $urandom_range(0, 40) == 0) stuck = 7;
            if (stuck > 0) begin
                rdy = 0;
                stuck--;
            end else begin
                rdy = ($urandom_range(0, 2) != 0);
            end
            if ($urandom_range(0, 300) == 0) async_reset("rnd_rst");
            else tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
